mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 15 +
 rtl/mem_responder_if.sv | 17 +
 rtl/mem_array.sv | 43 ++++
 rtl/mem_responder.sv | 168 ++++++++++++++++
 tb/tb_mem_responder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder slice.
package mem_responder_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam word_t MMIO_ADDR = 16'hFFFF;

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side memory bus: address/data/strobes out of the CPU, read data and ready back.
interface mem_responder_if;
    import mem_responder_pkg::*;

    word_t MAR;
    word_t MDR;
    logic  MEM_OE;
    logic  MEM_WE;
    word_t MDR_In;
    logic  R;

    modport master (output MAR, output MDR, output MEM_OE, output MEM_WE,
                    input MDR_In, input R);
    modport slave  (input MAR, input MDR, input MEM_OE, input MEM_WE,
                    output MDR_In, output R);

endinterface

// File: rtl/mem_array.sv
// Single-port RAM, 2**AddrW x 16: synchronous write, registered read.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned AddrW = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] addr_i,
    input  word_t            wdata_i,
    output word_t            rdata_o
);

    word_t mem_q [2**AddrW];
    word_t rdata_q, rdata_d;

    // Storage itself is never reset; only the read register is.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder with one-cycle ready pulse and strobe-release handshake.
// Optional MEM_RESPONDER_MMIO_EN maps 16'hFFFF to SW (read) and HEX_Out (write).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    mem_responder_if.slave bus,
    input  word_t          SW,
    output word_t          HEX_Out
);

    localparam logic [3:0] CntLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    word_t      addr_q, addr_d;
    word_t      data_q, data_d;
    logic       we_q, we_d;

    logic  req;
    word_t eff_addr;
    word_t eff_data;
    logic  eff_we;
    logic  commit_raw;
    logic  commit;
    logic  mmio_hit;
    logic  ram_we;
    logic  ram_re;
    word_t ram_rdata;

    // With zero wait states the access completes on the latching edge, so the
    // live bus must be used in IDLE instead of the not-yet-latched copy.
    always_comb begin
        req = bus.MEM_OE | bus.MEM_WE;
        if (state_q == IDLE) begin
            eff_addr = bus.MAR;
            eff_data = bus.MDR;
            eff_we   = bus.MEM_WE;
        end else begin
            eff_addr = addr_q;
            eff_data = data_q;
            eff_we   = we_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        we_d       = we_q;
        commit_raw = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d = bus.MAR;
                    data_d = bus.MDR;
                    we_d   = bus.MEM_WE;
                    if (WAIT_CYCLES > 0) begin
                        state_d = BUSY;
                        cnt_d   = CntLoad;
                    end else begin
                        state_d    = DONE;
                        commit_raw = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d    = DONE;
                    commit_raw = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: state_d = RELEASE;
            RELEASE: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A reset edge aborts the access: nothing commits on it.
    assign commit = commit_raw & ~Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
        addr_q <= addr_d;
        data_q <= data_d;
        we_q   <= we_d;
    end

    assign ram_we = commit & eff_we & ~mmio_hit;
    assign ram_re = commit & ~eff_we & ~mmio_hit;
    assign bus.R  = (state_q == DONE);

    mem_array #(
        .AddrW (ADDR_W)
    ) u_mem_array (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (eff_addr[ADDR_W-1:0]),
        .wdata_i (eff_data),
        .rdata_o (ram_rdata)
    );

`ifdef MEM_RESPONDER_MMIO_EN
    word_t hex_q, hex_d;
    word_t sw_q, sw_d;
    logic  sw_sel_q, sw_sel_d;

    assign mmio_hit = (eff_addr == MMIO_ADDR);

    // sw_sel_q picks which read register was last loaded, so MDR_In holds either.
    always_comb begin
        hex_d    = hex_q;
        sw_d     = sw_q;
        sw_sel_d = sw_sel_q;
        if (commit && eff_we && mmio_hit) begin
            hex_d = eff_data;
        end
        if (commit && !eff_we) begin
            sw_sel_d = mmio_hit;
            if (mmio_hit) begin
                sw_d = SW;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hex_q    <= '0;
            sw_q     <= '0;
            sw_sel_q <= 1'b0;
        end else begin
            hex_q    <= hex_d;
            sw_q     <= sw_d;
            sw_sel_q <= sw_sel_d;
        end
    end

    assign HEX_Out    = hex_q;
    assign bus.MDR_In = sw_sel_q ? sw_q : ram_rdata;
`else
    logic unused_io;

    assign mmio_hit   = 1'b0;
    assign HEX_Out    = '0;
    assign bus.MDR_In = ram_rdata;
    assign unused_io  = ^{SW, eff_addr};
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a 2-wait-state and a 0-wait-state instance driven in lockstep,
// checked every cycle against a transaction-level model plus literal spot checks.
module tb_mem_responder;

`ifdef MEM_RESPONDER_MMIO_EN
    localparam bit Mmio = 1'b1;
`else
    localparam bit Mmio = 1'b0;
`endif

    logic        Clk;
    logic        Reset;
    logic [15:0] SW;
    logic [15:0] hex_slow, hex_fast;

    mem_responder_if bus_slow ();
    mem_responder_if bus_fast ();

    mem_responder #(.WAIT_CYCLES(2), .ADDR_W(8)) dut_slow (
        .Clk(Clk), .Reset(Reset), .bus(bus_slow), .SW(SW), .HEX_Out(hex_slow)
    );
    mem_responder #(.WAIT_CYCLES(0), .ADDR_W(8)) dut_fast (
        .Clk(Clk), .Reset(Reset), .bus(bus_fast), .SW(SW), .HEX_Out(hex_fast)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Index 0 = slow (2 wait states), index 1 = fast (0 wait states).
    bit          pend      [2];
    bit          pend_we   [2];
    logic [15:0] pend_addr [2];
    logic [15:0] pend_data [2];
    int          r_at      [2];
    logic [15:0] mm        [2][256];
    logic [15:0] exp_mdr   [2];
    logic [15:0] exp_hex   [2];
    int          last_r_cyc[2];
    int          r_count   [2];
    int          last_req_edge;
    bit          rst_now;
    bit          exp_r;
    logic        r_act;
    logic [15:0] mdr_act, hex_act;

    function automatic int lat(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: an access completes W+1 edges after it is issued; at that moment the
    // write lands (storage or HEX) or the read value becomes the new MDR_In.
    initial begin
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; exp_mdr[i] = '0; exp_hex[i] = '0;
            last_r_cyc[i] = -1; r_count[i] = 0;
        end
        forever begin
            @(posedge Clk);
            rst_now = Reset;
            cyc++;
            #1;
            for (int i = 0; i < 2; i++) begin
                exp_r = 1'b0;
                if (rst_now) begin
                    pend[i]    = 1'b0;
                    exp_mdr[i] = '0;
                    exp_hex[i] = '0;
                end else if (pend[i] && cyc == r_at[i]) begin
                    exp_r   = 1'b1;
                    pend[i] = 1'b0;
                    if (Mmio && pend_addr[i] == 16'hFFFF) begin
                        if (pend_we[i]) exp_hex[i] = pend_data[i];
                        else            exp_mdr[i] = SW;
                    end else if (pend_we[i]) begin
                        mm[i][pend_addr[i][7:0]] = pend_data[i];
                    end else begin
                        exp_mdr[i] = mm[i][pend_addr[i][7:0]];
                    end
                end
                r_act   = (i == 0) ? bus_slow.R      : bus_fast.R;
                mdr_act = (i == 0) ? bus_slow.MDR_In : bus_fast.MDR_In;
                hex_act = (i == 0) ? hex_slow        : hex_fast;
                if (r_act === 1'b1) begin
                    last_r_cyc[i] = cyc;
                    r_count[i]++;
                end
                chk($sformatf("R[%0d]", i), {15'd0, r_act}, {15'd0, exp_r});
                chk($sformatf("MDR_In[%0d]", i), mdr_act, exp_mdr[i]);
                chk($sformatf("HEX_Out[%0d]", i), hex_act, exp_hex[i]);
            end
        end
    end

    task automatic drive(input bit we, input bit oe, input logic [15:0] a, input logic [15:0] d);
        bus_slow.MEM_WE = we; bus_slow.MEM_OE = oe; bus_slow.MAR = a; bus_slow.MDR = d;
        bus_fast.MEM_WE = we; bus_fast.MEM_OE = oe; bus_fast.MAR = a; bus_fast.MDR = d;
    endtask

    task automatic access(input bit we, input bit oe, input logic [15:0] a,
                          input logic [15:0] d, input int hold, input bit scramble);
        int guard;
        @(negedge Clk);
        drive(we, oe, a, d);
        last_req_edge = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b1; pend_we[i] = we; pend_addr[i] = a; pend_data[i] = d;
            r_at[i] = cyc + 1 + lat(i);
        end
        if (scramble) begin
            // Bus changes after the latching edge must not affect the access.
            @(negedge Clk);
            if (we && oe) drive(1'b1, 1'b1, 16'($urandom), 16'($urandom));
            else          drive(oe, we, 16'($urandom), 16'($urandom));
        end
        guard = 0;
        while ((pend[0] || pend[1]) && guard < 40) begin
            @(negedge Clk);
            guard++;
        end
        if (pend[0] || pend[1]) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: R not seen, pend=%0d%0d want 00", pend[0], pend[1]);
            pend[0] = 1'b0;
            pend[1] = 1'b0;
        end
        repeat (hold) @(negedge Clk);
        drive(1'b0, 1'b0, 16'($urandom), 16'($urandom));
        @(negedge Clk);
    endtask

    int r0, r1;
    logic [15:0] prev_mdr;
    logic [15:0] a;
    int op;

    initial begin
        Reset = 1'b1;
        SW    = 16'h0000;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_R_slow", {15'd0, bus_slow.R}, 16'd0);
        chk("rst_R_fast", {15'd0, bus_fast.R}, 16'd0);
        chk("rst_MDR_slow", bus_slow.MDR_In, 16'h0000);
        chk("rst_MDR_fast", bus_fast.MDR_In, 16'h0000);
        chk("rst_HEX_slow", hex_slow, 16'h0000);

        for (int i = 0; i < 16; i++) access(1'b1, 1'b0, 16'(i), 16'($urandom), 0, 1'b0);
        access(1'b1, 1'b0, 16'h00FF, 16'h5555, 0, 1'b0);
        access(1'b1, 1'b0, 16'h0020, 16'h1111, 0, 1'b0);

        access(1'b1, 1'b0, 16'h0012, 16'hBEEF, 0, 1'b0);
        access(1'b0, 1'b1, 16'h0012, 16'h0000, 0, 1'b0);
        chk("rd12_slow", bus_slow.MDR_In, 16'hBEEF);
        chk("rd12_fast", bus_fast.MDR_In, 16'hBEEF);
        chk("model_rd12", exp_mdr[0], 16'hBEEF);
        chk("lat_slow", 16'(last_r_cyc[0] - last_req_edge + 1), 16'd3);
        chk("lat_fast", 16'(last_r_cyc[1] - last_req_edge + 1), 16'd1);

        access(1'b1, 1'b0, 16'h0105, 16'hA5A5, 0, 1'b1);
        access(1'b0, 1'b1, 16'h0005, 16'h0000, 0, 1'b1);
        chk("alias_slow", bus_slow.MDR_In, 16'hA5A5);
        chk("alias_fast", bus_fast.MDR_In, 16'hA5A5);

        SW = 16'h1234;
        access(1'b1, 1'b0, 16'hFFFF, 16'h00AB, 0, 1'b0);
        access(1'b0, 1'b1, 16'hFFFF, 16'h0000, 0, 1'b0);
        chk("ffff_rd", bus_slow.MDR_In, Mmio ? 16'h1234 : 16'h00AB);
        chk("ffff_hex", hex_slow, Mmio ? 16'h00AB : 16'h0000);
        access(1'b0, 1'b1, 16'h00FF, 16'h0000, 0, 1'b0);
        chk("st255", bus_fast.MDR_In, Mmio ? 16'h5555 : 16'h00AB);

        prev_mdr = Mmio ? 16'h5555 : 16'h00AB;
        access(1'b1, 1'b1, 16'h0033, 16'h7777, 0, 1'b0);
        chk("both_hold_mdr", bus_slow.MDR_In, prev_mdr);
        access(1'b0, 1'b1, 16'h0033, 16'h0000, 0, 1'b0);
        chk("both_wrote", bus_slow.MDR_In, 16'h7777);

        r0 = r_count[0];
        r1 = r_count[1];
        access(1'b0, 1'b1, 16'h0012, 16'h0000, 5, 1'b0);
        chk("one_pulse_slow", 16'(r_count[0] - r0), 16'd1);
        chk("one_pulse_fast", 16'(r_count[1] - r1), 16'd1);

        // Reset while the slow instance is in BUSY on a write; the fast one has already committed.
        @(negedge Clk);
        drive(1'b1, 1'b0, 16'h0020, 16'h2222);
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b1; pend_we[i] = 1'b1; pend_addr[i] = 16'h0020; pend_data[i] = 16'h2222;
            r_at[i] = cyc + 1 + lat(i);
        end
        @(negedge Clk);
        Reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge Clk);
        Reset = 1'b0;
        chk("rstbusy_R", {15'd0, bus_slow.R}, 16'd0);
        chk("rstbusy_MDR", bus_slow.MDR_In, 16'h0000);
        access(1'b0, 1'b1, 16'h0020, 16'h0000, 0, 1'b0);
        chk("rstbusy_old_slow", bus_slow.MDR_In, 16'h1111);
        chk("rstbusy_new_fast", bus_fast.MDR_In, 16'h2222);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) SW = 16'($urandom);
            a = {8'($urandom), 8'(($urandom_range(0, 16) == 16) ? 8'hFF : 8'($urandom_range(0, 15)))};
            if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
            op = $urandom_range(0, 2);
            access(op != 0, op != 1, a, 16'($urandom), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
